nvram_xfer: RTL and testbench

//  Bulk initiator for the 256x8 NVRAM image, driving the array's second port.

---
 rtl/nvram_xfer.sv | 117 +++++++++++
 tb/tb_nvram_xfer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_xfer.sv
// Bulk SAVE/LOAD initiator for the 256x8 NVRAM image on the array's second port.
// SAVE streams every byte out on s_*; LOAD writes an l_* byte stream into the array.
module nvram_xfer #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start_save,
  input  logic          i_start_load,
  input  logic          i_abort,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_cpu_hold,
  output logic [DW-1:0] o_s_data,
  output logic          o_s_valid,
  input  logic          i_s_ready,
  input  logic [DW-1:0] i_l_data,
  input  logic          i_l_valid,
  output logic          o_l_ready,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_din,
  input  logic [DW-1:0] i_mem_dout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SV_RD   = 3'd1;
  localparam logic [2:0] S_SV_WAIT = 3'd2;
  localparam logic [2:0] S_SV_OUT  = 3'd3;
  localparam logic [2:0] S_LD_IN   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [2:0]    r_state;
  logic [AW:0]   r_addr;
  logic [DW-1:0] r_s_data;

  logic          w_busy;
  logic          w_abort;
  logic          w_s_hs;
  logic          w_l_acc;
  logic          w_last;
  logic [AW:0]   w_addr_nxt;

  assign w_busy = (r_state == S_SV_RD) || (r_state == S_SV_WAIT) ||
                  (r_state == S_SV_OUT) || (r_state == S_LD_IN);
  assign w_abort = i_abort && w_busy;

  // The counter is one bit wider than the array so the terminal count DEPTH is
  // representable; the address itself is held at DEPTH-1 rather than wrapping.
  assign w_addr_nxt = r_addr + 1'b1;
  assign w_last     = (w_addr_nxt == DEPTH);

  assign o_s_valid = (r_state == S_SV_OUT) && !i_abort;
  assign w_s_hs    = o_s_valid && i_s_ready;
  assign o_l_ready = (r_state == S_LD_IN) && !i_abort;
  assign w_l_acc   = o_l_ready && i_l_valid;

  assign o_busy     = w_busy;
  assign o_cpu_hold = w_busy;
  assign o_done     = (r_state == S_DONE);
  assign o_s_data   = r_s_data;
  assign o_mem_addr = r_addr[AW-1:0];
  assign o_mem_we   = w_l_acc;
  assign o_mem_din  = i_l_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_s_data <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start_save) begin
            r_state <= S_SV_RD;
            r_addr  <= '0;
          end else if (i_start_load) begin
            r_state <= S_LD_IN;
            r_addr  <= '0;
          end
        end
        S_SV_RD:   r_state <= S_SV_WAIT;
        S_SV_WAIT: begin
          r_s_data <= i_mem_dout;
          r_state  <= S_SV_OUT;
        end
        S_SV_OUT: begin
          if (w_s_hs) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= w_addr_nxt;
              r_state <= S_SV_RD;
            end
          end
        end
        S_LD_IN: begin
          if (w_l_acc) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_addr <= w_addr_nxt;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_xfer.sv
// Self-checking bench for nvram_xfer: a behavioural array model plus an expected
// image (refMem) that SAVE streams must reproduce and LOAD streams must update.
module tb_nvram_xfer;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          resetN;
  logic          startSave, startLoad, abortReq;
  logic          busy, done, cpuHold;
  logic [DW-1:0] sData;
  logic          sValid, sReady;
  logic [DW-1:0] lData;
  logic          lValid, lReady;
  logic [AW-1:0] memAddr;
  logic          memWe;
  logic [DW-1:0] memDin, memDout;

  logic [DW-1:0] ram    [DEPTH];
  logic [DW-1:0] refMem [DEPTH];

  int checks   = 0;
  int failures = 0;

  logic          obsHs, obsWe, obsDone, obsBusy, obsHold, obsSValid, obsLReady;
  logic [DW-1:0] obsSData, obsDin;
  logic [AW-1:0] obsAddr;

  always #5 clock = ~clock;

  nvram_xfer #(.AW(AW), .DW(DW)) dut (
    .i_clk        (clock),
    .i_rst_n      (resetN),
    .i_start_save (startSave),
    .i_start_load (startLoad),
    .i_abort      (abortReq),
    .o_busy       (busy),
    .o_done       (done),
    .o_cpu_hold   (cpuHold),
    .o_s_data     (sData),
    .o_s_valid    (sValid),
    .i_s_ready    (sReady),
    .i_l_data     (lData),
    .i_l_valid    (lValid),
    .o_l_ready    (lReady),
    .o_mem_addr   (memAddr),
    .o_mem_we     (memWe),
    .o_mem_din    (memDin),
    .i_mem_dout   (memDout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Samples the DUT at the falling edge, then advances one rising edge and
  // updates the registered-read array model just after it.
  task automatic applyStimulus();
    logic [DW-1:0] oldByte;
    @(negedge clock);
    obsHs     = sValid && sReady;
    obsSValid = sValid;
    obsSData  = sData;
    obsWe     = memWe;
    obsAddr   = memAddr;
    obsDin    = memDin;
    obsDone   = done;
    obsBusy   = busy;
    obsHold   = cpuHold;
    obsLReady = lReady;
    @(posedge clock);
    #1;
    oldByte = ram[obsAddr];
    if (obsWe) ram[obsAddr] = obsDin;
    memDout = oldByte;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " cpu_hold"}, 32'(cpuHold), 0);
    checkOutput({tag, " s_valid"}, 32'(sValid), 0);
    checkOutput({tag, " l_ready"}, 32'(lReady), 0);
    checkOutput({tag, " mem_we"}, 32'(memWe), 0);
    checkOutput({tag, " mem_addr"}, 32'(memAddr), 0);
    checkOutput({tag, " s_data"}, 32'(sData), 0);
  endtask

  task automatic preload(input bit randomFill);
    for (int n = 0; n < DEPTH; n++) begin
      ram[n]    = randomFill ? DW'($urandom) : (DW'(n) ^ 8'hA5);
      refMem[n] = ram[n];
    end
  endtask

  task automatic compareImage(input string tag);
    for (int n = 0; n < DEPTH; n++)
      checkOutput($sformatf("%s mem[%0d]", tag, n), 32'(ram[n]), 32'(refMem[n]));
  endtask

  task automatic runSave(input string tag, input bit randomReady, input bit alsoLoad, input bit checkTiming);
    int idx = 0;
    int edgeNo = 0;
    int doneCount = 0;
    int weCount = 0;
    int stableErr = 0;
    int holdErr = 0;
    logic holdPending = 1'b0;
    logic [DW-1:0] heldByte = '0;
    sReady    = 1'b1;
    startSave = 1'b1;
    startLoad = alsoLoad;
    applyStimulus();
    startSave = 1'b0;
    startLoad = 1'b0;
    while (doneCount == 0 && edgeNo < 4000) begin
      if (randomReady) begin
        sReady    = 1'($urandom_range(0, 1));
        startLoad = 1'($urandom_range(0, 1));
      end
      lValid = 1'($urandom_range(0, 1));
      lData  = DW'($urandom);
      edgeNo++;
      applyStimulus();
      if (obsWe || obsLReady) weCount++;
      if (obsHold !== obsBusy || (!obsDone && !obsBusy)) holdErr++;
      if (holdPending && !(obsSValid && obsSData == heldByte)) stableErr++;
      holdPending = obsSValid && !sReady;
      heldByte    = obsSData;
      if (obsHs) begin
        if (idx < DEPTH) checkOutput($sformatf("%s byte %0d", tag, idx), 32'(obsSData), 32'(refMem[idx]));
        if (checkTiming) checkOutput($sformatf("%s hs edge %0d", tag, idx), edgeNo, 3 + 3 * idx);
        idx++;
      end
      if (obsDone) begin
        doneCount++;
        checkOutput({tag, " done after all bytes"}, idx, DEPTH);
        if (checkTiming) checkOutput({tag, " done edge"}, edgeNo, 3 * DEPTH + 1);
      end
    end
    startLoad = 1'b0;
    lValid    = 1'b0;
    checkOutput({tag, " done count"}, doneCount, 1);
    checkOutput({tag, " byte count"}, idx, DEPTH);
    checkOutput({tag, " mem_we/l_ready seen"}, weCount, 0);
    checkOutput({tag, " s_data stability"}, stableErr, 0);
    checkOutput({tag, " busy/cpu_hold"}, holdErr, 0);
    applyStimulus();
    checkOutput({tag, " busy after"}, 32'(obsBusy), 0);
    checkOutput({tag, " done after"}, 32'(obsDone), 0);
    compareImage(tag);
  endtask

  task automatic runLoad(input string tag, input bit randomValid, input int abortAt);
    int idx = 0;
    int edgeNo = 0;
    int doneCount = 0;
    int weErr = 0;
    int addrErr = 0;
    int holdErr = 0;
    bit aborted = 0;
    startLoad = 1'b1;
    applyStimulus();
    startLoad = 1'b0;
    while (doneCount == 0 && !aborted && edgeNo < 4000) begin
      lValid    = randomValid ? 1'($urandom_range(0, 1)) : 1'b1;
      lData     = randomValid ? DW'($urandom) : DW'(255 - idx);
      abortReq  = (idx == abortAt);
      if (abortReq) lValid = 1'b1;
      sReady    = 1'($urandom_range(0, 1));
      startSave = 1'($urandom_range(0, 1));
      edgeNo++;
      applyStimulus();
      if (obsHold !== obsBusy || obsSValid) holdErr++;
      if (abortReq) begin
        aborted = 1;
        checkOutput({tag, " mem_we in abort cycle"}, 32'(obsWe), 0);
        checkOutput({tag, " l_ready in abort cycle"}, 32'(obsLReady), 0);
      end else if (obsDone) begin
        doneCount++;
        if (obsWe || obsBusy) weErr++;
        if (!randomValid) checkOutput({tag, " done edge"}, edgeNo, DEPTH + 1);
      end else begin
        if (obsWe !== lValid || !obsLReady || !obsBusy) weErr++;
        if (obsWe) begin
          if (obsAddr !== AW'(idx) || obsDin !== lData) addrErr++;
          if (idx < DEPTH) refMem[idx] = lData;
          idx++;
        end
      end
    end
    abortReq  = 1'b0;
    startSave = 1'b0;
    lValid    = 1'b0;
    if (abortAt >= 0) begin
      checkOutput({tag, " bytes before abort"}, idx, abortAt);
      applyStimulus();
      checkOutput({tag, " busy after abort"}, 32'(obsBusy), 0);
      for (int k = 0; k < 3; k++) begin
        if (obsDone) doneCount++;
        applyStimulus();
      end
      if (obsDone) doneCount++;
      checkOutput({tag, " no done on abort"}, doneCount, 0);
    end else begin
      checkOutput({tag, " done count"}, doneCount, 1);
      checkOutput({tag, " byte count"}, idx, DEPTH);
      applyStimulus();
      checkOutput({tag, " busy after"}, 32'(obsBusy), 0);
    end
    checkOutput({tag, " write strobes"}, weErr, 0);
    checkOutput({tag, " write addr/data"}, addrErr, 0);
    checkOutput({tag, " busy/cpu_hold"}, holdErr, 0);
    compareImage(tag);
  endtask

  initial begin
    resetN    = 1'b0;
    startSave = 1'b0;
    startLoad = 1'b0;
    abortReq  = 1'b0;
    sReady    = 1'b0;
    lValid    = 1'b0;
    lData     = '0;
    memDout   = '0;
    preload(1'b0);
    #12;
    checkIdleOutputs("reset");
    applyStimulus();
    applyStimulus();
    resetN = 1'b1;
    applyStimulus();

    $display("[TB] save with s_ready held high");
    preload(1'b0);
    runSave("save fixed", 1'b0, 1'b0, 1'b1);

    $display("[TB] save with random s_ready");
    preload(1'b1);
    runSave("save random", 1'b1, 1'b0, 1'b0);

    $display("[TB] continuous load");
    preload(1'b1);
    runLoad("load full", 1'b0, -1);

    $display("[TB] simultaneous start_save and start_load");
    preload(1'b1);
    runSave("save priority", 1'b0, 1'b1, 1'b1);

    $display("[TB] load aborted after 10 bytes");
    preload(1'b1);
    runLoad("load abort", 1'b1, 10);

    $display("[TB] load with random l_valid");
    runLoad("load random", 1'b1, -1);

    $display("[TB] reset in the middle of a save");
    preload(1'b1);
    sReady    = 1'b1;
    startSave = 1'b1;
    applyStimulus();
    startSave = 1'b0;
    for (int k = 0; k < 20; k++) applyStimulus();
    lData  = '0;
    resetN = 1'b0;
    #1;
    checkIdleOutputs("mid-save reset");
    applyStimulus();
    applyStimulus();
    resetN = 1'b1;
    applyStimulus();
    runSave("save after reset", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
